// File: rtl/alu_multicycle_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multicycle ALU: 4-bit operation codes, the
//   controller FSM state encoding and a helper that identifies the opcodes
//   executed by the iterative multiply/divide unit.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_ORR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_CBZ  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_UDIV = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_MOV  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL and UDIV take WIDTH+1 cycles; everything else completes in one.
    function automatic logic is_iterative(input logic [3:0] code);
        return (code == OP_MUL) || (code == OP_UDIV);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// -----------------------------------------------------------------------------
// alu_multicycle_if
//   Operand-side and result-side handshake bundle of the multicycle ALU.
//   master : operand preparation / result consumer (drives inValid, operands,
//            code, outReady)
//   slave  : the ALU (drives inReady, outValid, result, resultHi, flags)
//
//   Handshake: a transfer happens on a rising clock edge where the sender's
//   valid and the receiver's ready are both high. A sender holds valid and its
//   data stable until that edge; ready may depend on the other side's ready
//   (inReady follows outReady while a result is pending) but never on valid.
// -----------------------------------------------------------------------------
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] readData1;
    logic [WIDTH-1:0] readData2;
    logic [3:0]       aluControlCode;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] resultHi;
    logic             zeroFlag;
    logic             negativeFlag;
    logic             carryBit;
    logic             overflowFlag;
    logic             illegalOp;

    modport master (
        output inValid, readData1, readData2, aluControlCode, outReady,
        input  inReady, outValid, result, resultHi,
               zeroFlag, negativeFlag, carryBit, overflowFlag, illegalOp
    );

    modport slave (
        input  inValid, readData1, readData2, aluControlCode, outReady,
        output inReady, outValid, result, resultHi,
               zeroFlag, negativeFlag, carryBit, overflowFlag, illegalOp
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// -----------------------------------------------------------------------------
// alu_iter_muldiv
//   Iterative unsigned multiply (shift-add) and unsigned divide (restoring),
//   one step per clock, WIDTH steps per operation. Both share one adder.
//
//   Ports:
//     clock, resetN    clock, asynchronous active-low reset
//     start_i          load operands and begin (ignored unless idle)
//     is_div_i         1 = divide a_i / b_i, 0 = multiply a_i * b_i
//     a_i, b_i         operands, sampled with start_i
//     done_o           high during the cycle whose clock edge performs the
//                      final step; lo_o/hi_o then carry the final values
//     is_div_o         operation type of the current job
//     lo_o, hi_o       step results: product low/high, or quotient/remainder
//     div_by_zero_o    current job is a divide with b == 0
// -----------------------------------------------------------------------------
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic             is_div_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             div_by_zero_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q;
    logic             is_div_q;
    logic             dbz_q;
    logic [CNT_W-1:0] cnt_q;
    // acc_q: product high word / partial remainder
    // lo_q : multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is 1.
        add_x   = {1'b0, acc_q};
        add_y   = lo_q[0] ? {1'b0, opnd_q} : '0;
        add_cin = 1'b0;
        if (is_div_q) begin
            // Divide: trial subtraction of the divisor from the shifted
            // remainder; the carry out of the extra top bit means no borrow.
            add_x   = {acc_q, lo_q[WIDTH-1]};
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, add_cin};

        if (is_div_q) begin
            acc_d = add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], add_sum[WIDTH+1]};
        end else begin
            acc_d = add_sum[WIDTH:1];
            lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
        end else if (start_i && !busy_q) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div_i;
            dbz_q    <= is_div_i && (b_i == '0);
            cnt_q    <= CNT_W'(WIDTH - 1);
            acc_q    <= '0;
            lo_q     <= a_i;
            opnd_q   <= b_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // A zero divisor never borrows, so the quotient fills with ones and the
    // dividend shifts whole into the remainder: exactly all-ones and A.
    assign done_o        = busy_q && (cnt_q == '0);
    assign is_div_o      = is_div_q;
    assign lo_o          = lo_d;
    assign hi_o          = acc_d;
    assign div_by_zero_o = dbz_q;

endmodule

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   WIDTH-bit ALU with valid/ready handshakes on both sides. Logic and
//   add/sub ops finish in one cycle; MUL and UDIV run on alu_iter_muldiv and
//   take WIDTH+1 cycles. Results and NZCV/illegal flags are registered and
//   held while the consumer stalls.
//
//   Ports:
//     clock, resetN  clock, asynchronous active-low reset
//     bus            alu_multicycle_if slave: inValid/inReady, readData1/2,
//                    aluControlCode, outValid/outReady, result, resultHi,
//                    zeroFlag, negativeFlag, carryBit, overflowFlag, illegalOp
//     dbg_state_o    controller FSM state
// -----------------------------------------------------------------------------
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    alu_multicycle_if.slave       bus,
    output state_t                dbg_state_o
);
    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;
    logic             ill_q;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       code;
    logic             in_ready;
    logic             accept;
    logic             start_iter;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_res_d;
    logic             sc_c_d;
    logic             sc_v_d;
    logic             sc_ill_d;

    logic             md_done;
    logic             md_is_div;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_dbz;

    assign a    = bus.readData1;
    assign b    = bus.readData2;
    assign code = bus.aluControlCode;

    // A pending result frees the block only in the cycle it is taken.
    assign in_ready   = resetN && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_DONE) && bus.outReady));
    assign accept     = bus.inValid && in_ready;
    assign start_iter = accept && is_iterative(code);

    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} - {1'b0, b};   // bit WIDTH is the borrow
        sc_res_d = '0;
        sc_c_d   = 1'b0;
        sc_v_d   = 1'b0;
        sc_ill_d = 1'b0;
        case (code)
            OP_ADD: begin
                sc_res_d = add_full[WIDTH-1:0];
                sc_c_d   = add_full[WIDTH];
                sc_v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_d = sub_full[WIDTH-1:0];
                sc_c_d   = ~sub_full[WIDTH];
                sc_v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ORR:          sc_res_d = a | b;
            OP_AND:          sc_res_d = a & b;
            OP_XOR:          sc_res_d = a ^ b;
            OP_NOR:          sc_res_d = ~(a | b);
            OP_NAND:         sc_res_d = ~(a & b);
            OP_CBZ, OP_MOV:  sc_res_d = b;
            OP_MUL, OP_UDIV: sc_res_d = '0;   // produced by the iterative unit
            default:         sc_ill_d = 1'b1;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock         (clock),
        .resetN        (resetN),
        .start_i       (start_iter),
        .is_div_i      (code == OP_UDIV),
        .a_i           (a),
        .b_i           (b),
        .done_o        (md_done),
        .is_div_o      (md_is_div),
        .lo_o          (md_lo),
        .hi_o          (md_hi),
        .div_by_zero_o (md_dbz)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // Result taken with nothing new: fall back to idle.
                    // A same-cycle accept below overrides this.
                    if ((state_q == ST_DONE) && bus.outReady) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                    if (accept) begin
                        if (is_iterative(code)) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_BUSY;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                            result_q    <= sc_res_d;
                            result_hi_q <= '0;
                            zero_q      <= (sc_res_d == '0);
                            neg_q       <= sc_res_d[WIDTH-1];
                            carry_q     <= sc_c_d;
                            ovf_q       <= sc_v_d;
                            ill_q       <= sc_ill_d;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                        result_q    <= md_lo;
                        result_hi_q <= md_hi;
                        zero_q      <= (md_lo == '0);
                        neg_q       <= md_lo[WIDTH-1];
                        carry_q     <= md_dbz;
                        ovf_q       <= !md_is_div && (md_hi != '0);
                        ill_q       <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.inReady      = in_ready;
    assign bus.outValid     = out_valid_q;
    assign bus.result       = result_q;
    assign bus.resultHi     = result_hi_q;
    assign bus.zeroFlag     = zero_q;
    assign bus.negativeFlag = neg_q;
    assign bus.carryBit     = carry_q;
    assign bus.overflowFlag = ovf_q;
    assign bus.illegalOp    = ill_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Self-checking bench for alu_multicycle at WIDTH=32: reset, legacy ops,
//   flags, iterative MUL/UDIV, reset abort, backpressure and streaming.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         ill;
    } exp_t;

    logic   clock  = 1'b0;
    logic   resetN = 1'b0;
    state_t dbg_state;
    int     n_cmp  = 0;
    int     n_bad  = 0;
    exp_t   exp_q[$];

    alu_multicycle_if #(.WIDTH(W)) bus();

    alu_multicycle #(.WIDTH(W)) dut (
        .clock       (clock),
        .resetN      (resetN),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t            e;
        longint          sa, sb, sr;
        longint unsigned ua, ub, p;
        e  = '0;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        case (code)
            OP_ADD: begin
                sr    = sa + sb;
                e.res = W'(ua + ub);
                e.c   = ((ua + ub) >> W) != 0;
                e.v   = (sr > SMAX) || (sr < SMIN);
            end
            OP_SUB: begin
                sr    = sa - sb;
                e.res = W'(ua - ub);
                e.c   = (ua >= ub);
                e.v   = (sr > SMAX) || (sr < SMIN);
            end
            OP_ORR:  e.res = a | b;
            OP_AND:  e.res = a & b;
            OP_XOR:  e.res = a ^ b;
            OP_NOR:  e.res = ~(a | b);
            OP_NAND: e.res = ~(a & b);
            OP_CBZ:  e.res = b;
            OP_MOV:  e.res = b;
            OP_MUL: begin
                p     = ua * ub;
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
                e.v   = (e.hi != 0);
            end
            OP_UDIV: begin
                if (ub == 0) begin
                    e.res = '1;
                    e.hi  = a;
                    e.c   = 1'b1;
                end else begin
                    e.res = W'(ua / ub);
                    e.hi  = W'(ua % ub);
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[W-1];
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.res = bus.result;
        o.hi  = bus.resultHi;
        o.z   = bus.zeroFlag;
        o.n   = bus.negativeFlag;
        o.c   = bus.carryBit;
        o.v   = bus.overflowFlag;
        o.ill = bus.illegalOp;
        return o;
    endfunction

    function automatic logic [3:0] pick_single();
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        while (is_iterative(c)) c = 4'($urandom_range(0, 15));
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int k = 0;
        while (!bus.inReady && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        if (!bus.inReady) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ready: inReady=%b after %0d cycles, required 1", bus.inReady, k);
        end
    endtask

    // One operation: accept, measure latency, compare, then take the result.
    task automatic run_op(input string name, input logic [3:0] code, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, output exp_t got);
        exp_t e;
        int   lat;
        e = model(code, a, b);
        bus.outReady = 1'b0;
        wait_ready();
        bus.aluControlCode = code;
        bus.readData1      = a;
        bus.readData2      = b;
        bus.inValid        = 1'b1;
        @(posedge clock); #1;
        // Garbage after accept must not disturb the operation.
        bus.inValid        = 1'b0;
        bus.readData1      = $urandom;
        bus.readData2      = $urandom;
        bus.aluControlCode = 4'($urandom);
        lat = 1;
        while (!bus.outValid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        got = observe();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s outputs: got %h required %h", name, got, e);
        end
        bus.outReady = 1'b1;
        @(posedge clock); #1;
        bus.outReady = 1'b0;
        n_cmp++;
        if (bus.outValid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s outValid drop: got %b required 0", name, bus.outValid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN             = 1'b0;
        bus.inValid        = 1'b1;
        bus.aluControlCode = OP_ADD;
        bus.readData1      = 32'd7;
        bus.readData2      = 32'd9;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.inReady, bus.outValid} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_handshake: got inReady=%b outValid=%b required 0 0",
                     bus.inReady, bus.outValid);
        end
        n_cmp++;
        if (observe() !== exp_t'('0)) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", observe());
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        bus.inValid = 1'b0;
        resetN      = 1'b1;
        #1;
        n_cmp++;
        if (bus.inReady !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b required 1", bus.inReady);
        end
    endtask

    task automatic test_legacy();
        logic [3:0]   codes[10] = '{OP_ADD, OP_CBZ, OP_CBZ, OP_SUB, OP_AND,
                                    OP_ORR, OP_XOR, OP_NOR, OP_NAND, OP_MOV};
        logic [W-1:0] as[10]    = '{15, 15, 15, 10, 5, 5, 5, 5, 5, 5};
        logic [W-1:0] bs[10]    = '{15, 15, 0, 15, 15, 15, 10, 10, 10, 10};
        logic [W-1:0] rs[10]    = '{30, 15, 0, 32'hFFFF_FFFB, 5, 15, 15,
                                    32'hFFFF_FFF0, 32'hFFFF_FFFF, 10};
        logic         zs[10]    = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        exp_t got;
        for (int i = 0; i < 10; i++) begin
            run_op("legacy", codes[i], as[i], bs[i], 1, got);
            n_cmp++;
            if ({got.res, got.z} !== {rs[i], zs[i]}) begin
                n_bad++;
                $display("FAIL legacy_const[%0d]: got res=%h z=%b required res=%h z=%b",
                         i, got.res, got.z, rs[i], zs[i]);
            end
        end
    endtask

    task automatic test_flags();
        logic [3:0]   codes[4] = '{OP_ADD, OP_ADD, OP_SUB, 4'd15};
        logic [W-1:0] as[4]    = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 5, 123};
        logic [W-1:0] bs[4]    = '{1, 1, 5, 456};
        // {res, z, n, c, v, ill}
        logic [W+4:0] exps[4]  = '{{32'h0, 5'b10100}, {32'h8000_0000, 5'b01010},
                                   {32'h0, 5'b10100}, {32'h0, 5'b10001}};
        exp_t got;
        for (int i = 0; i < 4; i++) begin
            run_op("flags", codes[i], as[i], bs[i], 1, got);
            n_cmp++;
            if ({got.res, got.z, got.n, got.c, got.v, got.ill} !== exps[i]) begin
                n_bad++;
                $display("FAIL flags_const[%0d]: got %h required %h", i,
                         {got.res, got.z, got.n, got.c, got.v, got.ill}, exps[i]);
            end
        end
    endtask

    task automatic test_muldiv();
        exp_t         got;
        logic [3:0]   code;
        logic [W-1:0] a, b;
        run_op("mul_16x16", OP_MUL, 32'h0001_0000, 32'h0001_0000, W + 1, got);
        n_cmp++;
        if ({got.res, got.hi, got.v, got.z} !== {32'h0, 32'h1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL mul_const: got res=%h hi=%h v=%b z=%b required 0 1 1 1",
                     got.res, got.hi, got.v, got.z);
        end
        run_op("udiv_100_7", OP_UDIV, 100, 7, W + 1, got);
        n_cmp++;
        if ({got.res, got.hi} !== {32'd14, 32'd2}) begin
            n_bad++;
            $display("FAIL udiv_const: got %0d rem %0d required 14 rem 2", got.res, got.hi);
        end
        run_op("udiv_by_0", OP_UDIV, 100, 0, W + 1, got);
        n_cmp++;
        if ({got.res, got.hi, got.c} !== {32'hFFFF_FFFF, 32'd100, 1'b1}) begin
            n_bad++;
            $display("FAIL udiv0_const: got res=%h hi=%h c=%b required ffffffff 64 1",
                     got.res, got.hi, got.c);
        end
        for (int i = 0; i < 8; i++) begin
            code = (i % 2 == 0) ? OP_MUL : OP_UDIV;
            a    = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            run_op("muldiv_rand", code, a, b, W + 1, got);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t got;
        logic seen = 1'b0;
        bus.outReady = 1'b0;
        wait_ready();
        bus.aluControlCode = OP_MUL;
        bus.readData1      = $urandom;
        bus.readData2      = $urandom;
        bus.inValid        = 1'b1;
        @(posedge clock); #1;
        bus.inValid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        resetN = 1'b0;
        #1;
        n_cmp++;
        if ({bus.inReady, bus.outValid} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_reset: got inReady=%b outValid=%b required 0 0",
                     bus.inReady, bus.outValid);
        end
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.outValid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_result: got outValid seen=%b required 0", seen);
        end
        run_op("after_abort", OP_ADD, 1, 1, 1, got);
        n_cmp++;
        if (got.res !== 32'd2) begin
            n_bad++;
            $display("FAIL after_abort_const: got %0d required 2", got.res);
        end
    endtask

    task automatic test_backpressure();
        exp_t         snap, e;
        logic [W-1:0] a, b;
        int           k = 0;
        a = $urandom;
        b = $urandom;
        bus.outReady = 1'b0;
        wait_ready();
        bus.aluControlCode = OP_ADD;
        bus.readData1      = a;
        bus.readData2      = b;
        bus.inValid        = 1'b1;
        @(posedge clock); #1;
        // Next op presented while stalled; it must wait.
        bus.readData1 = 2;
        bus.readData2 = 3;
        while (!bus.outValid && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        snap = observe();
        n_cmp++;
        if (snap !== model(OP_ADD, a, b)) begin
            n_bad++;
            $display("FAIL bp_first: got %h required %h", snap, model(OP_ADD, a, b));
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if ({observe(), bus.outValid, bus.inReady} !== {snap, 2'b10}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got %h v=%b r=%b required %h v=1 r=0",
                         i, observe(), bus.outValid, bus.inReady, snap);
            end
        end
        bus.outReady = 1'b1;
        #1;
        n_cmp++;
        if (bus.inReady !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release_ready: got %b required 1", bus.inReady);
        end
        @(posedge clock); #1;
        bus.inValid = 1'b0;
        e = model(OP_ADD, 2, 3);
        n_cmp++;
        if ({bus.outValid, observe()} !== {1'b1, e} || bus.result !== 32'd5) begin
            n_bad++;
            $display("FAIL bp_next: got v=%b %h required v=1 %h", bus.outValid, observe(), e);
        end
        @(posedge clock); #1;
        bus.outReady = 1'b0;
        n_cmp++;
        if (bus.outValid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drop: got %b required 0", bus.outValid);
        end
    endtask

    // ---------------- scoreboard-driven streaming ----------------
    task automatic test_back_to_back(input int n_ops, input bit add_only);
        exp_t         e, got;
        logic [3:0]   code;
        logic [W-1:0] a, b;
        int           n_got = 0;
        int           first = -1;
        int           last  = -1;
        exp_q.delete();
        bus.outReady = 1'b0;
        wait_ready();
        bus.outReady = 1'b1;
        for (int cyc = 0; cyc < n_ops + 4; cyc++) begin
            if (bus.outValid) begin
                got = observe();
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got %h with nothing expected", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL stream_result: got %h required %h", got, e);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n_got++;
            end
            if (cyc < n_ops) begin
                code = add_only ? OP_ADD : pick_single();
                a    = $urandom;
                b    = $urandom;
                bus.aluControlCode = code;
                bus.readData1      = a;
                bus.readData2      = b;
                bus.inValid        = 1'b1;
            end else begin
                bus.inValid = 1'b0;
            end
            #1;
            if (bus.inValid && bus.inReady) exp_q.push_back(model(code, a, b));
            @(posedge clock); #1;
        end
        bus.outReady = 1'b0;
        n_cmp++;
        if (n_got !== n_ops || (last - first) !== (n_ops - 1) || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL stream_count: got %0d results over %0d cycles (%0d left), required %0d over %0d",
                     n_got, last - first + 1, exp_q.size(), n_ops, n_ops);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.inValid        = 1'b0;
        bus.outReady       = 1'b0;
        bus.readData1      = '0;
        bus.readData2      = '0;
        bus.aluControlCode = '0;
        test_reset();
        test_legacy();
        test_flags();
        test_muldiv();
        test_reset_mid_mul();
        test_backpressure();
        test_back_to_back(4, 1'b1);
        test_back_to_back(12, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle ARM-LP ALU. Covers all existing opcodes at configurable WIDTH.
- Adds iterative multiply and unsigned divide, a full NZCV flag set, and valid/ready handshakes on both sides.
- Sits between operand preparation (operands, control code) and the data cache / PC (result, flags).
- Controller must tolerate variable latency.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
- clock  input  1  processor clock; all state on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  operands and code valid.
- inReady  output  1  block accepts an operation this cycle.
- readData1  input  WIDTH  operand A.
- readData2  input  WIDTH  operand B.
- aluControlCode  input  4  operation select.
- outValid  output  1  result and flags valid.
- outReady  input  1  consumer takes the result this cycle.
- result  output  WIDTH  primary result.
- resultHi  output  WIDTH  MUL high word / DIV remainder; 0 otherwise.
- zeroFlag  output  1  result == 0.
- negativeFlag  output  1  result[WIDTH-1].
- carryBit  output  1  carry / no-borrow / divide-by-zero.
- overflowFlag  output  1  signed overflow / MUL high word nonzero.
- illegalOp  output  1  unknown code accepted.

Behaviour:
- Reset (async, resetN low):
  - state = IDLE, every output register cleared to 0, inReady = 0 while resetN low.
  - Reset mid-BUSY aborts the operation; no outValid for it.
- Accept occurs when inValid && inReady. inReady = (IDLE) || (DONE && outReady).
- Operands and code are captured at accept; inputs are ignored afterwards.
- Opcodes:
  - 2 ADD: A+B; C = carry-out; V = signed overflow.
  - 3 SUB: A-B; C = (A >= B unsigned); V = signed overflow.
  - 4 ORR, 6 AND, 9 XOR, 5 NOR, 12 NAND: bitwise; C = V = 0.
  - 7 CBZ: result = B; zero = (B == 0); C = V = 0.
  - 13 MOV: result = B; C = V = 0.
  - 10 MUL: unsigned 2*WIDTH product; result = low word, resultHi = high word; V = (high != 0); C = 0.
  - 11 UDIV: result = A/B, resultHi = A%B, C = V = 0.
    - B == 0: result = all-ones, resultHi = A, C = 1.
  - Any other code: result = 0, illegalOp = 1, zero = 1, other flags 0.
- Z and N are always derived from result (except CBZ, whose result is B anyway).
- FSM:
  - IDLE: accept single-cycle op -> DONE; accept MUL/DIV -> BUSY, cycle counter loaded with WIDTH-1.
  - BUSY: one shift-add / restoring-divide step per cycle; counter decrements; at 0 -> DONE.
  - DONE: outValid = 1.
    - outReady && inValid: accept the next op (same transitions as IDLE).
    - outReady && !inValid: -> IDLE.
    - !outReady: hold all outputs stable.
- Latency (accept edge to outValid high):
  - Single-cycle ops: 1 cycle. Back-to-back throughput is 1/cycle while outReady is high.
  - MUL/DIV: WIDTH+1 cycles; no overlap.
- outValid drops the cycle after the handshake unless a new single-cycle op was accepted.
- Outputs are registered; no combinational path from inputs to outputs, except inReady depending on outReady.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD=2, OP_SUB=3, OP_ORR=4, OP_NOR=5, OP_AND=6, OP_CBZ=7, OP_XOR=9, OP_MUL=10, OP_UDIV=11, OP_NAND=12, OP_MOV=13) and FSM state encodings.
- Sub-module alu_iter_muldiv:
  - Parametrised by WIDTH; start/done handshake.
  - Shares one WIDTH+1 adder between the multiply and divide steps.
  - Reports the divide-by-zero flag.

Test Plan (WIDTH=32):
- Reset: hold resetN low 3 cycles with inValid=1 -> inReady=0, outValid=0, all outputs 0. inReady=1 the first cycle after release. Assert resetN low mid-MUL -> outValid never rises; a following ADD 1+1 gives 2.
- Legacy ops, A=15, B=15:
  - ADD -> 30, Z=0.
  - CBZ -> result 15, Z=0; CBZ B=0 -> Z=1.
  - SUB A=10 -> 0xFFFFFFFB, N=1, C=0.
  - AND A=5 -> 5; ORR -> 15.
  - B=10: XOR -> 15; NOR -> 0xFFFFFFF0; NAND -> 0xFFFFFFFF; MOV -> 10.
  - Each with outValid exactly 1 cycle after accept.
- Flags:
  - ADD 0xFFFFFFFF+1 -> 0, Z=1, C=1, V=0.
  - ADD 0x7FFFFFFF+1 -> 0x80000000, N=1, V=1.
  - SUB 5-5 -> 0, Z=1, C=1.
  - Code 15 -> illegalOp=1, result 0.
- MUL/DIV:
  - MUL 0x10000*0x10000 -> result 0, resultHi 1, V=1, Z=1; outValid exactly 33 cycles after accept.
  - UDIV 100/7 -> 14 rem 2.
  - UDIV 100/0 -> 0xFFFFFFFF, resultHi 100, C=1.
- Backpressure:
  - Hold outReady=0 for 5 cycles in DONE -> outputs stable, inReady=0.
  - Raise outReady with inValid=1 (ADD 2+3) -> accepted same cycle, outValid stays high, result 5 next cycle.
  - Stream 4 ADDs with outReady=1 -> 4 results on consecutive cycles.
